apb_i2c_cmd_arbiter: RTL
========================

Name: apb_i2c_cmd_arbiter

Overview:
APB master-side arbiter and sequencer. It sits in front of the APB-to-I2C bridge slave and shares that single slave between NREQ on-chip requesters, such as a DMA engine and a CPU shim. It arbitrates pending commands, drives the APB SETUP/ACCESS protocol, waits for PREADY with a timeout, and returns read data and error status to the winning requester.

Parameters:
NREQ, 2, number of requesters (2..8).
TIMEOUT_CYC, 16, maximum ACCESS-phase cycles waiting for PREADY; 0 disables the timeout.
CW, 5, width of the timeout counter; must satisfy 2**CW > TIMEOUT_CYC.

Ports:
PCLK  in  1  clock; all logic on rising edge.
PRESETn  in  1  asynchronous active-low reset.
REQ  in  NREQ  per-requester command pending; held high until the matching GNT.
REQ_WRITE  in  NREQ  per-requester direction (1 = write).
REQ_ADDR  in  NREQ*32  per-requester address; slice i = [32*i+31:32*i].
REQ_WDATA  in  NREQ*32  per-requester write data; same slicing.
GNT  out  NREQ  one-cycle completion pulse to the served requester.
RSP_RDATA  out  32  read data, valid while GNT is high.
RSP_ERR  out  1  error flag, valid while GNT is high.
BUSY  out  1  high in SETUP or ACCESS.
PSELx  out  1  APB select.
PENABLE  out  1  APB enable.
PWRITE  out  1  APB direction.
PADDR  out  32  APB address.
PWDATA  out  32  APB write data.
PREADY  in  1  APB ready (1 = transfer complete).
PRDATA  in  32  APB read data.
PSLVERR  in  1  APB slave error.

Behaviour:
- Reset (asynchronous, PRESETn=0):
  - State = IDLE; all outputs 0.
  - Round-robin pointer LAST = NREQ-1, so requester 0 wins first.
  - Timeout counter = 0.
  - Asserting reset mid-transfer aborts the transfer immediately; no GNT is issued.
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE:
  - If any REQ bit is high, select the winner by scanning from LAST+1 modulo NREQ.
  - Latch the winner index and its WRITE/ADDR/WDATA into command registers.
  - Go to SETUP. The APB address and data come from these registers, not live inputs.
  - If no REQ bit is high, stay in IDLE.
- SETUP (exactly 1 cycle): PSELx=1, PENABLE=0, PWRITE/PADDR/PWDATA driven from the command registers. Go to ACCESS.
- ACCESS:
  - PSELx=1, PENABLE=1, address and data held stable; the counter increments each cycle.
  - If PREADY=1: complete normally.
  - Else if TIMEOUT_CYC!=0 and the counter reaches TIMEOUT_CYC: complete with timeout.
- Completion:
  - Next cycle: PSELx=0 and PENABLE=0, GNT[winner]=1 for exactly 1 cycle, LAST=winner, counter cleared, state=IDLE.
  - RSP_RDATA = PRDATA captured on the completing edge for reads; 0 for writes and for timeouts.
  - RSP_ERR = PSLVERR sampled on the completing edge, or 1 on timeout.
  - RSP_RDATA and RSP_ERR return to 0 when GNT drops.
- Throughput:
  - Minimum 3 cycles per transfer: IDLE, SETUP, ACCESS.
  - GNT overlaps the next IDLE arbitration cycle; back-to-back requests are not stalled further.
- PREADY and PSLVERR are ignored outside ACCESS.
- A requester may drop REQ before GNT; the latched transfer still completes and GNT still pulses.
- When the winner's REQ is still high on its GNT cycle, it must not win again while any other REQ is high (fairness via LAST).
- All REQ bits high continuously: grants rotate 0,1,..,NREQ-1,0.
- Address values are not checked; slave-side decode is the bridge's job.

Optional Feature:
APB_ARB_FIXED_PRIO_EN:
- Defined: fixed priority, lowest index wins, and LAST is unused. Timeout behaviour is unchanged.
- Undefined: round-robin as specified above.

Decomposition:
- Package apb_i2c_arb_pkg:
  - FSM state enum (IDLE/SETUP/ACCESS).
  - Bridge address constants: ADDR_TX_FIFO=32'd0, ADDR_RX_FIFO=32'd4, ADDR_CONFIG=32'd8, ADDR_TIMEOUT=32'd12.
  - A cmd_t struct (write, addr, wdata).
- Sub-module rr_arbiter:
  - Purely combinational: inputs REQ and LAST, outputs a one-hot winner and its index.
  - Contains the APB_ARB_FIXED_PRIO_EN selection.
- The top level holds the FSM, command registers, timeout counter and response registers.

Test Plan:
- Single write: REQ[0]=1, REQ_WRITE[0]=1, addr 8, wdata 0x00001234, PREADY=1 in first ACCESS -> SETUP at cycle 1, ACCESS at cycle 2, PADDR=8, PWDATA=0x1234, GNT[0] at cycle 3, RSP_ERR=0.
- Read with wait states: REQ[1] read addr 4, PREADY low for 3 ACCESS cycles, PRDATA=0xA5A5A5A5 when PREADY=1 -> ACCESS lasts 4 cycles with PADDR stable, GNT[1] with RSP_RDATA=0xA5A5A5A5.
- Fairness: REQ=2'b11 held for 4 transfers -> GNT order 0,1,0,1; none served twice in a row.
- Timeout: PREADY stuck 0, TIMEOUT_CYC=16 -> exactly 16 ACCESS cycles, then GNT, RSP_ERR=1, RSP_RDATA=0, FSM back in IDLE.
- Slave error: read addr 12 with PSLVERR=1 and PREADY=1 -> GNT with RSP_ERR=1; next transfer returns RSP_ERR=0.
- Reset mid-ACCESS: drop PRESETn in ACCESS -> PSELx/PENABLE/BUSY go to 0 without waiting for a clock, no GNT; after release, requester 0 wins first.

Source files
------------

// File: rtl/apb_i2c_arb_pkg.sv
// Shared types and constants for the APB-to-I2C command arbiter.
package apb_i2c_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_SETUP  = 2'd1,
    ARB_ACCESS = 2'd2
  } arb_state_e;

  // Register map of the APB-to-I2C bridge slave.
  localparam logic [31:0] ADDR_TX_FIFO = 32'd0;
  localparam logic [31:0] ADDR_RX_FIFO = 32'd4;
  localparam logic [31:0] ADDR_CONFIG  = 32'd8;
  localparam logic [31:0] ADDR_TIMEOUT = 32'd12;

  // One latched APB command.
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  // Width of a requester index (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_i2c_cmd_arbiter_rr_arbiter.sv
// Combinational requester selection: round-robin after 'last', or fixed
// priority (lowest index wins) when APB_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter
  import apb_i2c_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt_oh_c,
  output logic [IW-1:0]   gnt_idx_c,
  output logic            gnt_vld_c
);

`ifdef APB_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last;

  // Lowest pending index wins.
  always_comb begin
    gnt_vld_c = 1'b0;
    gnt_idx_c = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_vld_c = 1'b1;
        gnt_idx_c = IW'(i);
      end
    end
    gnt_oh_c = gnt_vld_c ? (NREQ'(1) << gnt_idx_c) : '0;
  end
`else
  logic [IW-1:0] cand;

  // Scan from last+1 around the ring; first pending requester wins.
  always_comb begin
    gnt_vld_c = 1'b0;
    gnt_idx_c = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IW'((32'(last) + k) % NREQ);
      if (!gnt_vld_c && req[cand]) begin
        gnt_vld_c = 1'b1;
        gnt_idx_c = cand;
      end
    end
    gnt_oh_c = gnt_vld_c ? (NREQ'(1) << gnt_idx_c) : '0;
  end
`endif

endmodule

// File: rtl/apb_i2c_cmd_arbiter.sv
// Shares one APB-to-I2C bridge slave between NREQ requesters: arbitrates,
// runs APB SETUP/ACCESS with a PREADY timeout, returns data/error with GNT.
// Build option: APB_ARB_FIXED_PRIO_EN selects fixed priority arbitration.
module apb_i2c_cmd_arbiter
  import apb_i2c_arb_pkg::*;
#(
  parameter int unsigned NREQ        = 2,
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CW          = 5
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic [NREQ-1:0]      REQ,
  input  logic [NREQ-1:0]      REQ_WRITE,
  input  logic [NREQ*32-1:0]   REQ_ADDR,
  input  logic [NREQ*32-1:0]   REQ_WDATA,
  output logic [NREQ-1:0]      GNT,
  output logic [31:0]          RSP_RDATA,
  output logic                 RSP_ERR,
  output logic                 BUSY,
  output logic                 PSELx,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [31:0]          PADDR,
  output logic [31:0]          PWDATA,
  input  logic                 PREADY,
  input  logic [31:0]          PRDATA,
  input  logic                 PSLVERR
);

  localparam int unsigned IW = idx_width(NREQ);

  localparam logic [1:0] IDLE   = ARB_IDLE;
  localparam logic [1:0] SETUP  = ARB_SETUP;
  localparam logic [1:0] ACCESS = ARB_ACCESS;

  logic [1:0]      state_q, state_d;
  cmd_t            cmd_q, cmd_d, win_cmd;
  logic [IW-1:0]   idx_q, idx_d, last_q, last_d;
  logic [NREQ-1:0] oh_q, oh_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic            timeout_hit;
  logic            psel_d, penable_d, busy_d, err_d;
  logic [NREQ-1:0] gnt_d;
  logic [31:0]     rdata_d;

  logic [NREQ-1:0] arb_oh;
  logic [IW-1:0]   arb_idx;
  logic            arb_vld;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req       (REQ),
    .last      (last_q),
    .gnt_oh_c  (arb_oh),
    .gnt_idx_c (arb_idx),
    .gnt_vld_c (arb_vld)
  );

  // Pick the winning requester's command fields.
  always_comb begin
    win_cmd = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_idx == IW'(i)) begin
        win_cmd.write = REQ_WRITE[i];
        win_cmd.addr  = REQ_ADDR[32*i +: 32];
        win_cmd.wdata = REQ_WDATA[32*i +: 32];
      end
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    idx_d       = idx_q;
    oh_d        = oh_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    cnt_inc     = cnt_q + CW'(1);
    timeout_hit = (TIMEOUT_CYC != 0) && (cnt_inc == CW'(TIMEOUT_CYC));
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    busy_d      = 1'b0;
    gnt_d       = '0;
    rdata_d     = '0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          cmd_d   = win_cmd;
          idx_d   = arb_idx;
          oh_d    = arb_oh;
          state_d = SETUP;
          psel_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        cnt_d     = '0;
        psel_d    = 1'b1;
        penable_d = 1'b1;
        busy_d    = 1'b1;
      end
      ACCESS: begin
        if (PREADY || timeout_hit) begin
          state_d = IDLE;
          gnt_d   = oh_q;
          last_d  = idx_q;
          cnt_d   = '0;
          err_d   = PREADY ? PSLVERR : 1'b1;
          rdata_d = (PREADY && !cmd_q.write) ? PRDATA : '0;
        end else begin
          cnt_d     = cnt_inc;
          psel_d    = 1'b1;
          penable_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, command and output registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      idx_q     <= '0;
      oh_q      <= '0;
      last_q    <= IW'(NREQ - 1);
      cnt_q     <= '0;
      PSELx     <= 1'b0;
      PENABLE   <= 1'b0;
      BUSY      <= 1'b0;
      GNT       <= '0;
      RSP_RDATA <= '0;
      RSP_ERR   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      idx_q     <= idx_d;
      oh_q      <= oh_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      PSELx     <= psel_d;
      PENABLE   <= penable_d;
      BUSY      <= busy_d;
      GNT       <= gnt_d;
      RSP_RDATA <= rdata_d;
      RSP_ERR   <= err_d;
    end
  end

  assign PWRITE = cmd_q.write;
  assign PADDR  = cmd_q.addr;
  assign PWDATA = cmd_q.wdata;

endmodule
